display_page_scheduler: RTL and testbench
=========================================

Name: display_page_scheduler

Overview:
- Sequences what the 4-digit parking display shows. It rotates vehicle count and available spaces, inserts a fee page when a fee is posted, and forces an alarm page while the alarm is high.
- Converts the selected binary value to 4 BCD digits with an iterative shift-add-3 engine, one bit per cycle.
- Delivers each page to the display driver over a valid/ready handshake.
- Sits between the parking FSM/counters and the 7-segment display module.

Parameters:
- DWELL_CYCLES, 1000, clock cycles each page stays on the display after it is accepted (minimum 2).
- FEE_HOLD_PAGES, 3, number of consecutive fee-page presentations after each fee_valid pulse (minimum 1).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset; the block is in reset while reset==0.
- vehicle_count  input  6  current occupancy, binary.
- available_spaces  input  6  free spaces, binary.
- fee_amount  input  8  fee in whole units, binary.
- fee_valid  input  1  one-cycle pulse; latches fee_amount.
- alarm  input  1  level; alarm page has priority while high.
- disp_ready  input  1  display driver accepts the page when disp_ready and disp_valid are both high on a clock edge.
- disp_valid  output  1  page data valid.
- bcd_digits  output  16  digit3..digit0, 4 bits each; 0-9 = numerals, 4'hE = "E", 4'hF = blank.
- page_id  output  2  0 COUNT, 1 SPACES, 2 FEE, 3 ALARM.
- busy  output  1  high in the SELECT, CONVERT and PRESENT states.

Behaviour:
- Reset (reset==0 at an edge): state=IDLE; bcd_digits=16'h0000, disp_valid=0, page_id=0, busy=0; fee_reg=0, fee_pending=0, fee_left=0; rotation pointer=COUNT; dwell counter=0.
- States: IDLE, SELECT, CONVERT, PRESENT, DWELL.
- IDLE -> SELECT on the first edge with reset==1.
- SELECT, 1 cycle, priority order:
  - alarm==1: page ALARM.
  - else fee_pending: page FEE.
  - else the rotation pointer page.
- SELECT datapath:
  - Latches the chosen source, zero-extended to 8 bits.
  - vehicle_count and available_spaces are sampled only here; later changes wait for the next SELECT.
- ALARM page: skips CONVERT; next state is PRESENT with bcd_digits=16'hEEEE.
- Other pages: CONVERT for exactly 8 cycles, one bit per cycle, standard double-dabble into 12 BCD bits; digit3 is always 0.
- Latency: SELECT at cycle N, CONVERT N+1..N+8, disp_valid rises at N+9.
- PRESENT:
  - bcd_digits and page_id update on entry and are held stable.
  - disp_valid=1 until an edge with disp_ready==1.
  - Alarm changes do not abort PRESENT.
  - On handshake: disp_valid=0 next cycle, go to DWELL with the counter loaded to DWELL_CYCLES-1.
- DWELL:
  - Decrement each cycle; at 0 go to SELECT.
  - Rising alarm during DWELL or CONVERT aborts to SELECT on the next edge, unless the current page is already ALARM.
- Rotation:
  - After a COUNT or SPACES page is accepted, the pointer toggles.
  - FEE and ALARM pages do not move the pointer.
  - When alarm falls, the next SELECT resumes from the pointer.
- Fee:
  - fee_valid latches fee_reg, sets fee_pending=1, fee_left=FEE_HOLD_PAGES.
  - Each accepted FEE page decrements fee_left; fee_pending clears when it reaches 0.
  - fee_valid while pending reloads both value and count, effective for the next SELECT.
  - fee_valid in the same cycle as a FEE handshake: reload wins.
  - fee_valid concurrent with alarm: latched; shown after the alarm clears.
- Width rules:
  - 63 -> 16'h0063; 255 -> 16'h0255; 0 -> 16'h0000.
  - No overflow is possible.
- Reset mid-operation (any state): return to reset values on the next edge; a pending fee is discarded.

Optional Feature:
- Macro: DISP_BLANK_LZ_EN.
- Defined: leading zero digits are replaced with 4'hF, always keeping digit0 (0 -> 16'hFFF0, 75 -> 16'hFF75). The ALARM page is unaffected.
- Undefined: leading zeros are shown as 4'h0.

Test Plan:
- Rotation, DWELL_CYCLES=8, disp_ready tied 1, vehicle_count=5, available_spaces=58 -> pages alternate 0,1,0,1; digits 16'h0005 and 16'h0058; disp_valid rises 9 cycles after each SELECT.
- fee_valid with fee_amount=255, FEE_HOLD_PAGES=3 during a COUNT dwell -> next three pages are page_id=2, 16'h0255; rotation then resumes at SPACES.
- Backpressure: disp_ready=0 for 20 cycles during PRESENT with vehicle_count changing 5->6 -> disp_valid stays 1, bcd_digits stays 16'h0005, handshake on the first ready edge.
- Alarm mid-CONVERT -> PRESENT with page 3, 16'hEEEE within 2 cycles; alarm cleared -> the next page is the pending fee if any, else the pointer page.
- reset=0 for one cycle during DWELL with a fee pending -> all outputs return to reset values; the first post-reset page is COUNT; no FEE page appears.
- With DISP_BLANK_LZ_EN defined: vehicle_count=0 -> 16'hFFF0; fee_amount=75 -> 16'hFF75.

Source files
------------

// File: rtl/display_page_scheduler.sv
// Page sequencer for the 4-digit parking display.
// Rotates COUNT/SPACES pages, inserts FEE pages after a posted fee, forces
// the ALARM page while alarm is high, converts binary to BCD with a
// one-bit-per-cycle double-dabble engine and hands each page to the display
// driver over valid/ready.
// Optional build macro: DISP_BLANK_LZ_EN (blank leading zero digits).
module display_page_scheduler #(
  parameter int unsigned DWELL_CYCLES   = 1000,
  parameter int unsigned FEE_HOLD_PAGES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  vehicle_count,
  input  logic [5:0]  available_spaces,
  input  logic [7:0]  fee_amount,
  input  logic        fee_valid,
  input  logic        alarm,
  input  logic        disp_ready,
  output logic        disp_valid,
  output logic [15:0] bcd_digits,
  output logic [1:0]  page_id,
  output logic        busy
);

  localparam int unsigned DwellW = $clog2(DWELL_CYCLES);
  localparam int unsigned FeeW   = $clog2(FEE_HOLD_PAGES + 1);

  localparam logic [1:0] PageCount  = 2'd0;
  localparam logic [1:0] PageSpaces = 2'd1;
  localparam logic [1:0] PageFee    = 2'd2;
  localparam logic [1:0] PageAlarm  = 2'd3;

  typedef enum logic [2:0] {StIdle, StSelect, StConvert, StPresent, StDwell} state_e;

  state_e            state_q, state_d;
  logic              ptr_q, ptr_d;            // 0: COUNT next, 1: SPACES next
  logic [1:0]        cur_page_q, cur_page_d;
  logic [7:0]        bin_q, bin_d;
  logic [11:0]       bcd_q, bcd_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [DwellW-1:0] dwell_q, dwell_d;
  logic [7:0]        fee_reg_q, fee_reg_d;
  logic              fee_pending_q, fee_pending_d;
  logic [FeeW-1:0]   fee_left_q, fee_left_d;
  logic              disp_valid_q, disp_valid_d;
  logic [15:0]       bcd_digits_q, bcd_digits_d;
  logic [1:0]        page_id_q, page_id_d;

  logic [11:0]       dd_adj;
  logic [11:0]       dd_bcd;
  logic [7:0]        dd_bin;
  logic              handshake;

  // Final digit formatting; digit3 is always zero for an 8-bit source.
  function automatic logic [15:0] fmt_digits(input logic [11:0] d);
`ifdef DISP_BLANK_LZ_EN
    logic [15:0] r;
    r = {4'hF, d};
    if (d[11:8] == 4'd0) begin
      r[11:8] = 4'hF;
      if (d[7:4] == 4'd0) r[7:4] = 4'hF;
    end
    return r;
`else
    return {4'h0, d};
`endif
  endfunction

  // One double-dabble step: add 3 to any digit >= 5, then shift left one bit.
  always_comb begin
    dd_adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) dd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
    dd_bcd = {dd_adj[10:0], bin_q[7]};
    dd_bin = {bin_q[6:0], 1'b0};
  end

  assign handshake = (state_q == StPresent) && disp_ready;

  // Next-state, datapath and fee bookkeeping.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cur_page_d    = cur_page_q;
    bin_d         = bin_q;
    bcd_d         = bcd_q;
    bit_cnt_d     = bit_cnt_q;
    dwell_d       = dwell_q;
    fee_reg_d     = fee_reg_q;
    fee_pending_d = fee_pending_q;
    fee_left_d    = fee_left_q;
    disp_valid_d  = disp_valid_q;
    bcd_digits_d  = bcd_digits_q;
    page_id_d     = page_id_q;

    unique case (state_q)
      StIdle: state_d = StSelect;
      StSelect: begin
        bit_cnt_d = 3'd0;
        bcd_d     = 12'd0;
        if (alarm) begin
          cur_page_d   = PageAlarm;
          state_d      = StPresent;
          bcd_digits_d = 16'hEEEE;
          page_id_d    = PageAlarm;
          disp_valid_d = 1'b1;
        end else begin
          state_d = StConvert;
          if (fee_pending_q) begin
            cur_page_d = PageFee;
            bin_d      = fee_reg_q;
          end else if (ptr_q) begin
            cur_page_d = PageSpaces;
            bin_d      = {2'b00, available_spaces};
          end else begin
            cur_page_d = PageCount;
            bin_d      = {2'b00, vehicle_count};
          end
        end
      end
      StConvert: begin
        bin_d     = dd_bin;
        bcd_d     = dd_bcd;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (alarm) begin
          state_d = StSelect;
        end else if (bit_cnt_q == 3'd7) begin
          state_d      = StPresent;
          bcd_digits_d = fmt_digits(dd_bcd);
          page_id_d    = cur_page_q;
          disp_valid_d = 1'b1;
        end
      end
      StPresent: begin
        if (disp_ready) begin
          disp_valid_d = 1'b0;
          state_d      = StDwell;
          dwell_d      = DwellW'(DWELL_CYCLES - 1);
          if (cur_page_q == PageCount || cur_page_q == PageSpaces) ptr_d = ~ptr_q;
        end
      end
      StDwell: begin
        if (alarm && cur_page_q != PageAlarm) begin
          state_d = StSelect;
        end else if (dwell_q == '0) begin
          state_d = StSelect;
        end else begin
          dwell_d = dwell_q - DwellW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // A new fee pulse overrides the decrement of a concurrent FEE handshake.
    if (fee_valid) begin
      fee_reg_d     = fee_amount;
      fee_pending_d = 1'b1;
      fee_left_d    = FeeW'(FEE_HOLD_PAGES);
    end else if (handshake && cur_page_q == PageFee) begin
      fee_left_d = fee_left_q - FeeW'(1);
      if (fee_left_q == FeeW'(1)) fee_pending_d = 1'b0;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StIdle;
      ptr_q         <= 1'b0;
      cur_page_q    <= PageCount;
      bin_q         <= 8'd0;
      bcd_q         <= 12'd0;
      bit_cnt_q     <= 3'd0;
      dwell_q       <= '0;
      fee_reg_q     <= 8'd0;
      fee_pending_q <= 1'b0;
      fee_left_q    <= '0;
      disp_valid_q  <= 1'b0;
      bcd_digits_q  <= 16'h0000;
      page_id_q     <= PageCount;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cur_page_q    <= cur_page_d;
      bin_q         <= bin_d;
      bcd_q         <= bcd_d;
      bit_cnt_q     <= bit_cnt_d;
      dwell_q       <= dwell_d;
      fee_reg_q     <= fee_reg_d;
      fee_pending_q <= fee_pending_d;
      fee_left_q    <= fee_left_d;
      disp_valid_q  <= disp_valid_d;
      bcd_digits_q  <= bcd_digits_d;
      page_id_q     <= page_id_d;
    end
  end

  assign disp_valid = disp_valid_q;
  assign bcd_digits = bcd_digits_q;
  assign page_id    = page_id_q;
  assign busy       = (state_q == StSelect) || (state_q == StConvert) ||
                      (state_q == StPresent);

endmodule

// File: tb/tb_display_page_scheduler.sv
// Directed self-checking bench for display_page_scheduler (DWELL_CYCLES=8,
// FEE_HOLD_PAGES=3). Outputs are sampled on the falling clock edge.
module tb_display_page_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  vehicle_count;
  logic [5:0]  available_spaces;
  logic [7:0]  fee_amount;
  logic        fee_valid;
  logic        alarm;
  logic        disp_ready;
  logic        disp_valid;
  logic [15:0] bcd_digits;
  logic [1:0]  page_id;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  display_page_scheduler #(
    .DWELL_CYCLES  (8),
    .FEE_HOLD_PAGES(3)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .vehicle_count   (vehicle_count),
    .available_spaces(available_spaces),
    .fee_amount      (fee_amount),
    .fee_valid       (fee_valid),
    .alarm           (alarm),
    .disp_ready      (disp_ready),
    .disp_valid      (disp_valid),
    .bcd_digits      (bcd_digits),
    .page_id         (page_id),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  // Expected digits for a numeric page, given the hand-computed zero-padded form.
  function automatic logic [15:0] ex(input logic [15:0] d);
`ifdef DISP_BLANK_LZ_EN
    logic [15:0] r;
    r = d;
    r[15:12] = 4'hF;
    if (d[11:8] == 4'd0) begin
      r[11:8] = 4'hF;
      if (d[7:4] == 4'd0) r[7:4] = 4'hF;
    end
    return r;
`else
    return d;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the next page to be offered; lat = cycles from SELECT.
  task automatic get_page(output logic [1:0] pid, output logic [15:0] dig, output int lat);
    int   n;
    int   sel_at;
    logic pb;
    n = 0;
    sel_at = 0;
    pb = busy;
    while (n < 300) begin
      @(negedge clk);
      n++;
      if (busy && !pb) sel_at = n;
      pb = busy;
      if (disp_valid) break;
    end
    chk("page_offered", {31'd0, disp_valid}, 32'd1);
    pid = page_id;
    dig = bcd_digits;
    lat = n - sel_at;
  endtask

  task automatic page(input string tag, input logic [1:0] epid, input logic [15:0] edig,
                      input bit check_lat);
    logic [1:0]  pid;
    logic [15:0] dig;
    int          lat;
    get_page(pid, dig, lat);
    chk({tag, "_page_id"}, {30'd0, pid}, {30'd0, epid});
    chk({tag, "_digits"}, {16'd0, dig}, {16'd0, edig});
    if (check_lat) chk({tag, "_latency"}, lat, 32'd9);
  endtask

  task automatic wait_select();
    int   n;
    logic pb;
    n = 0;
    pb = busy;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (busy && !pb) break;
      pb = busy;
    end
    chk("select_seen", n < 100, 32'd1);
  endtask

  initial begin
    int n;
    reset            = 1'b0;
    vehicle_count    = 6'd5;
    available_spaces = 6'd58;
    fee_amount       = 8'd0;
    fee_valid        = 1'b0;
    alarm            = 1'b0;
    disp_ready       = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_valid", {31'd0, disp_valid}, 32'd0);
    chk("rst_digits", {16'd0, bcd_digits}, 32'h0000);
    chk("rst_page", {30'd0, page_id}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;

    // Plain rotation
    page("rot1", 2'd0, ex(16'h0005), 1'b1);
    page("rot2", 2'd1, ex(16'h0058), 1'b1);
    page("rot3", 2'd0, ex(16'h0005), 1'b1);
    page("rot4", 2'd1, ex(16'h0058), 1'b1);
    page("rot5", 2'd0, ex(16'h0005), 1'b1);

    // Fee posted during a COUNT dwell
    @(negedge clk);
    fee_amount = 8'd255;
    fee_valid  = 1'b1;
    @(negedge clk);
    fee_valid  = 1'b0;
    page("fee255_a", 2'd2, ex(16'h0255), 1'b1);
    page("fee255_b", 2'd2, ex(16'h0255), 1'b1);
    page("fee255_c", 2'd2, ex(16'h0255), 1'b1);
    page("after_fee", 2'd1, ex(16'h0058), 1'b1);

    // Backpressure on a COUNT page while vehicle_count changes
    @(negedge clk);
    disp_ready = 1'b0;
    page("bp", 2'd0, ex(16'h0005), 1'b1);
    vehicle_count = 6'd6;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_valid_held", {31'd0, disp_valid}, 32'd1);
      chk("bp_digits_held", {16'd0, bcd_digits}, {16'd0, ex(16'h0005)});
    end
    disp_ready = 1'b1;
    @(negedge clk);
    chk("bp_valid_drop", {31'd0, disp_valid}, 32'd0);
    page("bp_next", 2'd1, ex(16'h0058), 1'b1);
    page("bp_newcount", 2'd0, ex(16'h0006), 1'b1);

    // Alarm raised mid-CONVERT of a SPACES page
    wait_select();
    repeat (3) @(negedge clk);
    alarm = 1'b1;
    n = 0;
    while (!disp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("alarm_latency_le2", n <= 2, 32'd1);
    chk("alarm_page", {30'd0, page_id}, 32'd3);
    chk("alarm_digits", {16'd0, bcd_digits}, 32'hEEEE);
    @(negedge clk);
    fee_amount = 8'd75;
    fee_valid  = 1'b1;
    @(negedge clk);
    fee_valid  = 1'b0;
    alarm      = 1'b0;
    page("fee75_a", 2'd2, ex(16'h0075), 1'b1);
    page("fee75_b", 2'd2, ex(16'h0075), 1'b1);
    page("fee75_c", 2'd2, ex(16'h0075), 1'b1);
    page("resume_ptr", 2'd1, ex(16'h0058), 1'b1);

    // Reset pulse during DWELL with a fee pending
    page("pre_rst", 2'd0, ex(16'h0006), 1'b1);
    @(negedge clk);
    fee_amount = 8'd9;
    fee_valid  = 1'b1;
    @(negedge clk);
    fee_valid  = 1'b0;
    reset      = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", {31'd0, disp_valid}, 32'd0);
    chk("mid_rst_digits", {16'd0, bcd_digits}, 32'h0000);
    chk("mid_rst_page", {30'd0, page_id}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    page("post_rst1", 2'd0, ex(16'h0006), 1'b1);
    page("post_rst2", 2'd1, ex(16'h0058), 1'b1);

    // Width boundaries 63 and 0
    vehicle_count    = 6'd63;
    available_spaces = 6'd0;
    page("count63", 2'd0, ex(16'h0063), 1'b1);
    page("spaces0", 2'd1, ex(16'h0000), 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
